// File: rtl/npu_axil_pkg.sv
`default_nettype none
// ============================================================================
// npu_axil_pkg : op codes, AXI response codes, NPU register map, FSM states
// Rev 1.0
// ============================================================================
package npu_axil_pkg;

   localparam logic [1:0] c_OP_WRITE = 2'd0;
   localparam logic [1:0] c_OP_READ  = 2'd1;
   localparam logic [1:0] c_OP_POLL  = 2'd2;
   localparam logic [1:0] c_OP_RSVD  = 2'd3;

   localparam logic [1:0] c_RESP_OKAY   = 2'b00;
   localparam logic [1:0] c_RESP_EXOKAY = 2'b01;
   localparam logic [1:0] c_RESP_SLVERR = 2'b10;
   localparam logic [1:0] c_RESP_DECERR = 2'b11;

   localparam logic [4:0] c_REG_WEIGHT = 5'h00;
   localparam logic [4:0] c_REG_BIAS   = 5'h04;
   localparam logic [4:0] c_REG_OUT    = 5'h08;
   localparam logic [4:0] c_REG_LAYER  = 5'h0C;
   localparam logic [4:0] c_REG_NEURON = 5'h10;
   localparam logic [4:0] c_REG_RDDATA = 5'h14;
   localparam logic [4:0] c_REG_STAT   = 5'h18;
   localparam logic [4:0] c_REG_CTRL   = 5'h1C;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WR_REQ  = 3'd1,
      ST_WR_RESP = 3'd2,
      ST_RD_REQ  = 3'd3,
      ST_RD_DATA = 3'd4,
      ST_RSP     = 3'd5
   } state_t;

endpackage
`default_nettype wire

// File: rtl/npu_axil_master.sv
`default_nettype none
// ============================================================================
// npu_axil_master : command-stream driven AXI4-Lite initiator (write/read/poll)
// Rev 1.0
// ============================================================================
module npu_axil_master
   import npu_axil_pkg::*;
#(
   parameter int C_M_AXI_ADDR_WIDTH = 5,
   parameter int C_M_AXI_DATA_WIDTH = 32,
   parameter int POLL_LIMIT         = 1024
) (
   input  logic                              M_AXI_ACLK,
   input  logic                              M_AXI_ARESET,
   input  logic                              cmd_valid,
   output logic                              cmd_ready,
   input  logic [1:0]                        cmd_op,
   input  logic [C_M_AXI_ADDR_WIDTH-1:0]     cmd_addr,
   input  logic [C_M_AXI_DATA_WIDTH-1:0]     cmd_data,
   output logic                              rsp_valid,
   input  logic                              rsp_ready,
   output logic [C_M_AXI_DATA_WIDTH-1:0]     rsp_data,
   output logic [1:0]                        rsp_resp,
   output logic                              rsp_timeout,
   output logic                              busy,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
   output logic [2:0]                        M_AXI_AWPROT,
   output logic                              M_AXI_AWVALID,
   input  logic                              M_AXI_AWREADY,
   output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
   output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
   output logic                              M_AXI_WVALID,
   input  logic                              M_AXI_WREADY,
   input  logic [1:0]                        M_AXI_BRESP,
   input  logic                              M_AXI_BVALID,
   output logic                              M_AXI_BREADY,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
   output logic [2:0]                        M_AXI_ARPROT,
   output logic                              M_AXI_ARVALID,
   input  logic                              M_AXI_ARREADY,
   input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
   input  logic [1:0]                        M_AXI_RRESP,
   input  logic                              M_AXI_RVALID,
   output logic                              M_AXI_RREADY
);

   localparam int                 c_CNT_W    = $clog2(POLL_LIMIT + 1);
   localparam logic [c_CNT_W-1:0] c_POLL_MAX = c_CNT_W'(POLL_LIMIT);

   state_t                          r_state, w_state_n;
   logic [1:0]                      r_op, w_op_n;
   logic [C_M_AXI_ADDR_WIDTH-1:0]   r_addr, w_addr_n;
   logic [C_M_AXI_DATA_WIDTH-1:0]   r_data, w_data_n;
   logic                            r_aw_done, w_aw_done_n;
   logic                            r_w_done, w_w_done_n;
   logic [c_CNT_W-1:0]              r_cnt, w_cnt_n;
   logic [C_M_AXI_DATA_WIDTH-1:0]   w_rsp_data_n;
   logic [1:0]                      w_rsp_resp_n;
   logic                            w_rsp_to_n;

   assign M_AXI_AWADDR = r_addr;
   assign M_AXI_ARADDR = r_addr;
   assign M_AXI_WDATA  = r_data;
   assign M_AXI_WSTRB  = '1;
   assign M_AXI_AWPROT = 3'b000;
   assign M_AXI_ARPROT = 3'b000;

   always_comb begin
      w_state_n    = r_state;
      w_op_n       = r_op;
      w_addr_n     = r_addr;
      w_data_n     = r_data;
      w_aw_done_n  = r_aw_done;
      w_w_done_n   = r_w_done;
      w_cnt_n      = r_cnt;
      w_rsp_data_n = rsp_data;
      w_rsp_resp_n = rsp_resp;
      w_rsp_to_n   = rsp_timeout;
      case (r_state)
         ST_IDLE: begin
            if (cmd_valid && cmd_ready) begin
               w_op_n      = cmd_op;
               w_addr_n    = cmd_addr;
               w_data_n    = cmd_data;
               w_aw_done_n = 1'b0;
               w_w_done_n  = 1'b0;
               w_cnt_n     = '0;
               w_rsp_to_n  = 1'b0;
               case (cmd_op)
                  c_OP_WRITE: w_state_n = ST_WR_REQ;
                  c_OP_READ,
                  c_OP_POLL:  w_state_n = ST_RD_REQ;
                  default: begin
                     w_state_n    = ST_RSP;
                     w_rsp_data_n = '0;
                     w_rsp_resp_n = c_RESP_SLVERR;
                  end
               endcase
            end
         end
         ST_WR_REQ: begin
            w_aw_done_n = r_aw_done | (M_AXI_AWVALID & M_AXI_AWREADY);
            w_w_done_n  = r_w_done  | (M_AXI_WVALID  & M_AXI_WREADY);
            if (w_aw_done_n && w_w_done_n)
               w_state_n = ST_WR_RESP;
         end
         ST_WR_RESP: begin
            if (M_AXI_BVALID && M_AXI_BREADY) begin
               w_rsp_data_n = '0;
               w_rsp_resp_n = M_AXI_BRESP;
               w_state_n    = ST_RSP;
            end
         end
         ST_RD_REQ: begin
            if (M_AXI_ARVALID && M_AXI_ARREADY)
               w_state_n = ST_RD_DATA;
         end
         ST_RD_DATA: begin
            if (M_AXI_RVALID && M_AXI_RREADY) begin
               w_rsp_data_n = M_AXI_RDATA;
               w_rsp_resp_n = M_AXI_RRESP;
               w_state_n    = ST_RSP;
               // A poll keeps re-reading while the masked bits stay clear and the slave answers OKAY
               if (r_op == c_OP_POLL && (M_AXI_RDATA & r_data) == '0 && M_AXI_RRESP == c_RESP_OKAY) begin
                  w_cnt_n = r_cnt + c_CNT_W'(1);
                  if (w_cnt_n == c_POLL_MAX)
                     w_rsp_to_n = 1'b1;
                  else
                     w_state_n = ST_RD_REQ;
               end
            end
         end
         ST_RSP: begin
            if (rsp_ready)
               w_state_n = ST_IDLE;
         end
         default: w_state_n = ST_IDLE;
      endcase
   end

   // Every output is registered from the next-state view so nothing combinational reaches a port
   always_ff @(posedge M_AXI_ACLK) begin
      if (M_AXI_ARESET) begin
         r_state       <= ST_IDLE;
         r_op          <= c_OP_WRITE;
         r_addr        <= '0;
         r_data        <= '0;
         r_aw_done     <= 1'b0;
         r_w_done      <= 1'b0;
         r_cnt         <= '0;
         cmd_ready     <= 1'b0;
         rsp_valid     <= 1'b0;
         rsp_data      <= '0;
         rsp_resp      <= '0;
         rsp_timeout   <= 1'b0;
         busy          <= 1'b0;
         M_AXI_AWVALID <= 1'b0;
         M_AXI_WVALID  <= 1'b0;
         M_AXI_BREADY  <= 1'b0;
         M_AXI_ARVALID <= 1'b0;
         M_AXI_RREADY  <= 1'b0;
      end else begin
         r_state       <= w_state_n;
         r_op          <= w_op_n;
         r_addr        <= w_addr_n;
         r_data        <= w_data_n;
         r_aw_done     <= w_aw_done_n;
         r_w_done      <= w_w_done_n;
         r_cnt         <= w_cnt_n;
         cmd_ready     <= (w_state_n == ST_IDLE);
         rsp_valid     <= (w_state_n == ST_RSP);
         rsp_data      <= w_rsp_data_n;
         rsp_resp      <= w_rsp_resp_n;
         rsp_timeout   <= w_rsp_to_n;
         busy          <= (w_state_n != ST_IDLE);
         M_AXI_AWVALID <= (w_state_n == ST_WR_REQ) && !w_aw_done_n;
         M_AXI_WVALID  <= (w_state_n == ST_WR_REQ) && !w_w_done_n;
         M_AXI_BREADY  <= (w_state_n == ST_WR_RESP);
         M_AXI_ARVALID <= (w_state_n == ST_RD_REQ);
         M_AXI_RREADY  <= (w_state_n == ST_RD_DATA);
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_npu_axil_master.sv
`default_nettype none
// ============================================================================
// tb_npu_axil_master : vector table, corner sequences and random traffic
// against an AXI4-Lite register slave model. Rev 1.0
// ============================================================================
module tb_npu_axil_master;

   localparam int c_PL = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid = 1'b0, cmd_ready;
   logic [1:0]  cmd_op = 2'd0;
   logic [4:0]  cmd_addr = 5'd0;
   logic [31:0] cmd_data = 32'd0;
   logic        rsp_valid, rsp_ready = 1'b0;
   logic [31:0] rsp_data;
   logic [1:0]  rsp_resp;
   logic        rsp_timeout, busy;
   logic [4:0]  AWADDR, ARADDR;
   logic [2:0]  AWPROT, ARPROT;
   logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
   logic        ARVALID, ARREADY, RVALID, RREADY;
   logic [31:0] WDATA, RDATA;
   logic [3:0]  WSTRB;
   logic [1:0]  BRESP, RRESP;

   always #5 clk = ~clk;

   npu_axil_master #(.C_M_AXI_ADDR_WIDTH(5), .C_M_AXI_DATA_WIDTH(32), .POLL_LIMIT(c_PL)) dut (
      .M_AXI_ACLK(clk), .M_AXI_ARESET(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
      .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout), .busy(busy),
      .M_AXI_AWADDR(AWADDR), .M_AXI_AWPROT(AWPROT), .M_AXI_AWVALID(AWVALID), .M_AXI_AWREADY(AWREADY),
      .M_AXI_WDATA(WDATA), .M_AXI_WSTRB(WSTRB), .M_AXI_WVALID(WVALID), .M_AXI_WREADY(WREADY),
      .M_AXI_BRESP(BRESP), .M_AXI_BVALID(BVALID), .M_AXI_BREADY(BREADY),
      .M_AXI_ARADDR(ARADDR), .M_AXI_ARPROT(ARPROT), .M_AXI_ARVALID(ARVALID), .M_AXI_ARREADY(ARREADY),
      .M_AXI_RDATA(RDATA), .M_AXI_RRESP(RRESP), .M_AXI_RVALID(RVALID), .M_AXI_RREADY(RREADY)
   );

   // ---------------- slave model (register file, STAT clears on read) ----------------
   int          aw_delay = 0, w_delay = 0, ar_delay = 0;
   logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
   bit          b_hold = 1'b0;
   int          stat_fire_at = -1;
   int          stat_reads = 0, aw_beats = 0, w_beats = 0, ar_beats = 0, prot_strb_bad = 0;
   logic [31:0] mem [8];
   int          aw_cnt, w_cnt, ar_cnt;
   bit          aw_got, w_got;
   logic [2:0]  aw_idx;
   logic [31:0] w_dat;

   always @(posedge clk) begin : slave
      bit ag, wg;
      logic [2:0] ai, ri;
      logic [31:0] wd, rd;
      if (rst) begin
         AWREADY <= 0; WREADY <= 0; BVALID <= 0; ARREADY <= 0; RVALID <= 0;
         BRESP <= 0; RRESP <= 0; RDATA <= 0;
         aw_got <= 0; w_got <= 0; aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0;
         aw_idx <= 0; w_dat <= 0;
         for (int i = 0; i < 8; i++) mem[i] = 32'd0;
      end else begin
         ag = aw_got; wg = w_got; ai = aw_idx; wd = w_dat;
         if (AWVALID && AWREADY) begin
            ag = 1; ai = AWADDR[4:2]; aw_beats++; AWREADY <= 0;
            if (AWPROT != 3'b000) prot_strb_bad++;
         end else if (AWVALID && !aw_got) begin
            if (aw_cnt >= aw_delay) begin AWREADY <= 1; aw_cnt <= 0; end
            else aw_cnt <= aw_cnt + 1;
         end
         if (WVALID && WREADY) begin
            wg = 1; wd = WDATA; w_beats++; WREADY <= 0;
            if (WSTRB != 4'hF) prot_strb_bad++;
         end else if (WVALID && !w_got) begin
            if (w_cnt >= w_delay) begin WREADY <= 1; w_cnt <= 0; end
            else w_cnt <= w_cnt + 1;
         end
         if (BVALID && BREADY) BVALID <= 0;
         if (ag && wg && !BVALID && !b_hold) begin
            mem[ai] = wd; BVALID <= 1; BRESP <= bresp_cfg; ag = 0; wg = 0;
         end
         aw_got <= ag; w_got <= wg; aw_idx <= ai; w_dat <= wd;
         if (RVALID && RREADY) RVALID <= 0;
         if (ARVALID && ARREADY) begin
            ARREADY <= 0; ar_beats++; ri = ARADDR[4:2];
            if (ARPROT != 3'b000) prot_strb_bad++;
            if (ri == 3'd6) begin
               stat_reads++;
               if (stat_reads == stat_fire_at) mem[6] = 32'd1;
               rd = mem[6]; mem[6] = 32'd0;
            end else rd = mem[ri];
            RVALID <= 1; RDATA <= rd; RRESP <= rresp_cfg;
         end else if (ARVALID && !RVALID) begin
            if (ar_cnt >= ar_delay) begin ARREADY <= 1; ar_cnt <= 0; end
            else ar_cnt <= ar_cnt + 1;
         end
      end
   end

   // ---------------- checking helpers ----------------
   int n_cmp = 0, n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic do_cmd(input logic [1:0] op, input logic [4:0] addr, input logic [31:0] data,
                         input int hold, output logic [31:0] d, output logic [1:0] r, output logic t,
                         output int lat, output logic [2:0] first_v, output bit split,
                         output bit cr_seen, output bit unstable, output bit rdy_after);
      int w;
      d = '0; r = '0; t = 0; lat = -1; first_v = '0; split = 0; cr_seen = 0; unstable = 0; rdy_after = 0;
      w = 0;
      @(negedge clk);
      while (!cmd_ready && w < 50) begin @(negedge clk); w++; end
      if (!cmd_ready) begin
         n_cmp++; n_bad++;
         $display("FAIL cmd_ready_wait: got 0, expected 1 within 50 cycles");
         return;
      end
      cmd_valid = 1; cmd_op = op; cmd_addr = addr; cmd_data = data;
      @(posedge clk); #1 cmd_valid = 0;
      for (int c = 1; c <= 200; c++) begin
         @(negedge clk);
         if (c == 1) first_v = {AWVALID, WVALID, ARVALID};
         if (AWVALID && !WVALID) split = 1;
         if (cmd_ready) cr_seen = 1;
         if (rsp_valid) begin lat = c; break; end
      end
      if (lat < 0) begin
         n_cmp++; n_bad++;
         $display("FAIL rsp_wait: got no rsp_valid, expected one within 200 cycles");
         return;
      end
      d = rsp_data; r = rsp_resp; t = rsp_timeout;
      for (int k = 0; k < hold; k++) begin
         @(negedge clk);
         if (rsp_valid !== 1'b1 || rsp_data !== d || rsp_resp !== r || rsp_timeout !== t ||
             cmd_ready || AWVALID || WVALID || ARVALID) unstable = 1;
      end
      rsp_ready = 1;
      @(posedge clk); #1 rsp_ready = 0;
      @(negedge clk);
      rdy_after = cmd_ready;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [1:0] op; logic [4:0] addr; logic [31:0] data;
      logic [1:0] bresp; logic [1:0] rresp;
      logic [31:0] e_data; logic [1:0] e_resp; logic e_to; int e_lat; int e_ar;
   } vec_t;

   vec_t        tbl [11];
   logic [31:0] ref_mem [8];

   initial begin : main
      logic [31:0] d; logic [1:0] r; logic t; int lat; logic [2:0] fv;
      bit sp, crs, uns, rda;
      int ar0, aw0, w0;
      string nm;

      tbl[0]  = '{2'd0, 5'h0C, 32'h2,        2'b00, 2'b00, 32'h0,        2'b00, 1'b0, 4,  0};
      tbl[1]  = '{2'd1, 5'h0C, 32'h0,        2'b00, 2'b00, 32'h2,        2'b00, 1'b0, 4,  1};
      tbl[2]  = '{2'd0, 5'h10, 32'hDEADBEEF, 2'b00, 2'b00, 32'h0,        2'b00, 1'b0, 4,  0};
      tbl[3]  = '{2'd1, 5'h10, 32'h0,        2'b00, 2'b00, 32'hDEADBEEF, 2'b00, 1'b0, 4,  1};
      tbl[4]  = '{2'd2, 5'h0C, 32'h2,        2'b00, 2'b00, 32'h2,        2'b00, 1'b0, 4,  1};
      tbl[5]  = '{2'd2, 5'h0C, 32'h1,        2'b00, 2'b00, 32'h2,        2'b00, 1'b1, 13, 4};
      tbl[6]  = '{2'd3, 5'h04, 32'h55,       2'b00, 2'b00, 32'h0,        2'b10, 1'b0, -1, 0};
      tbl[7]  = '{2'd1, 5'h0C, 32'h0,        2'b00, 2'b10, 32'h2,        2'b10, 1'b0, 4,  1};
      tbl[8]  = '{2'd2, 5'h0C, 32'h1,        2'b00, 2'b10, 32'h2,        2'b10, 1'b0, 4,  1};
      tbl[9]  = '{2'd0, 5'h00, 32'h55,       2'b10, 2'b00, 32'h0,        2'b10, 1'b0, 4,  0};
      tbl[10] = '{2'd1, 5'h00, 32'h0,        2'b00, 2'b00, 32'h55,       2'b00, 1'b0, 4,  1};

      // reset state
      repeat (3) @(negedge clk);
      chk("reset_outputs", {31'd0, cmd_ready, rsp_valid, busy, AWVALID, WVALID, BREADY, ARVALID, RREADY},
          32'd0);
      chk("reset_rsp", {rsp_data[29:0], rsp_resp}, 32'd0);
      rst = 0;
      @(negedge clk);
      chk("cmd_ready_after_reset", {31'd0, cmd_ready}, 32'd1);

      for (int i = 0; i < 11; i++) begin
         bresp_cfg = tbl[i].bresp; rresp_cfg = tbl[i].rresp;
         ar0 = ar_beats; aw0 = aw_beats; w0 = w_beats;
         do_cmd(tbl[i].op, tbl[i].addr, tbl[i].data, 0, d, r, t, lat, fv, sp, crs, uns, rda);
         nm = $sformatf("v%0d", i);
         chk({nm, "_data"}, d, tbl[i].e_data);
         chk({nm, "_resp"}, {30'd0, r}, {30'd0, tbl[i].e_resp});
         chk({nm, "_timeout"}, {31'd0, t}, {31'd0, tbl[i].e_to});
         if (tbl[i].e_lat >= 0) chk({nm, "_latency"}, lat, tbl[i].e_lat);
         chk({nm, "_ar_beats"}, ar_beats - ar0, tbl[i].e_ar);
         chk({nm, "_aw_w_beats"}, {aw_beats - aw0, w_beats - w0},
             (tbl[i].op == 2'd0) ? {32'd1, 32'd1} : 64'd0);
         chk({nm, "_first_valids"}, {29'd0, fv},
             (tbl[i].op == 2'd0) ? 32'd6 : (tbl[i].op == 2'd3) ? 32'd0 : 32'd1);
         chk({nm, "_cmd_ready_busy_back2back"}, {30'd0, crs, rda}, 32'd1);
      end
      bresp_cfg = 2'b00; rresp_cfg = 2'b00;

      // status bit appears on the third read of STAT
      stat_fire_at = stat_reads + 3;
      ar0 = ar_beats;
      do_cmd(2'd2, 5'h18, 32'h1, 0, d, r, t, lat, fv, sp, crs, uns, rda);
      chk("stat_poll_data", d, 32'h1);
      chk("stat_poll_timeout", {31'd0, t}, 32'd0);
      chk("stat_poll_ar_beats", ar_beats - ar0, 32'd3);
      chk("stat_poll_latency", lat, 32'd10);
      do_cmd(2'd1, 5'h18, 32'h0, 0, d, r, t, lat, fv, sp, crs, uns, rda);
      chk("stat_cleared", d, 32'h0);

      // status never set: poll exhausts its attempts
      stat_fire_at = -1;
      ar0 = ar_beats;
      do_cmd(2'd2, 5'h18, 32'h1, 0, d, r, t, lat, fv, sp, crs, uns, rda);
      chk("poll_timeout_flag", {31'd0, t}, 32'd1);
      chk("poll_timeout_ar_beats", ar_beats - ar0, c_PL);
      chk("poll_timeout_data", d, 32'h0);

      // AWREADY late, SLVERR, response held off for 5 cycles
      aw_delay = 3; bresp_cfg = 2'b10;
      do_cmd(2'd0, 5'h1C, 32'hA5A5_0001, 5, d, r, t, lat, fv, sp, crs, uns, rda);
      chk("slow_aw_w_drops_first", {31'd0, sp}, 32'd1);
      chk("slow_aw_resp", {30'd0, r}, 32'd2);
      chk("slow_aw_hold_stable", {31'd0, uns}, 32'd0);
      chk("slow_aw_cmd_ready_low", {31'd0, crs}, 32'd0);
      aw_delay = 0; bresp_cfg = 2'b00;

      // reset while waiting for B
      b_hold = 1;
      @(negedge clk);
      cmd_valid = 1; cmd_op = 2'd0; cmd_addr = 5'h08; cmd_data = 32'h77;
      @(posedge clk); #1 cmd_valid = 0;
      for (int c = 0; c < 20 && !BREADY; c++) @(negedge clk);
      @(negedge clk);
      chk("in_wr_resp_before_reset", {31'd0, BREADY}, 32'd1);
      rst = 1;
      @(posedge clk); #1;
      chk("reset_mid_txn_outputs", {25'd0, cmd_ready, rsp_valid, busy, AWVALID, WVALID, BREADY, ARVALID},
          32'd0);
      @(negedge clk);
      rst = 0; b_hold = 0;
      @(posedge clk); #1;
      chk("cmd_ready_after_mid_reset", {31'd0, cmd_ready}, 32'd1);
      begin
         bit saw_rsp;
         saw_rsp = 0;
         for (int c = 0; c < 10; c++) begin @(negedge clk); if (rsp_valid) saw_rsp = 1; end
         chk("no_rsp_after_reset", {31'd0, saw_rsp}, 32'd0);
      end

      // reserved op: SLVERR, no AXI traffic
      ar0 = ar_beats; aw0 = aw_beats; w0 = w_beats;
      do_cmd(2'd3, 5'h1C, 32'hFFFF_FFFF, 0, d, r, t, lat, fv, sp, crs, uns, rda);
      chk("rsvd_resp", {30'd0, r}, 32'd2);
      chk("rsvd_data", d, 32'd0);
      chk("rsvd_no_axi", (ar_beats - ar0) + (aw_beats - aw0) + (w_beats - w0), 32'd0);

      // random traffic against a register-file reference (memory cleared by the reset above)
      for (int i = 0; i < 8; i++) ref_mem[i] = 32'd0;
      for (int n = 0; n < 40; n++) begin
         logic [1:0]  op, er;
         logic [2:0]  idx;
         logic [31:0] dat, ed;
         logic        et;
         int          ea;
         op  = 2'($urandom_range(0, 2));
         idx = 3'($urandom_range(0, 6));
         if (idx == 3'd6) idx = 3'd7;
         dat = (op == 2'd2) ? (32'h1 << $urandom_range(0, 31)) : $urandom;
         aw_delay = $urandom_range(0, 3); w_delay = $urandom_range(0, 3); ar_delay = $urandom_range(0, 3);
         bresp_cfg = ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b00;
         rresp_cfg = ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b00;
         et = 0; ea = 0;
         if (op == 2'd0) begin
            ref_mem[idx] = dat; ed = 32'd0; er = bresp_cfg;
         end else begin
            ed = ref_mem[idx]; er = rresp_cfg; ea = 1;
            if (op == 2'd2 && rresp_cfg == 2'b00 && (ref_mem[idx] & dat) == 32'd0) begin
               et = 1; ea = c_PL;
            end
         end
         ar0 = ar_beats;
         do_cmd(op, {idx, 2'b00}, dat, 0, d, r, t, lat, fv, sp, crs, uns, rda);
         nm = $sformatf("rnd%0d_op%0d", n, op);
         chk({nm, "_rsp"}, {d[28:0], r, t}, {ed[28:0], er, et});
         chk({nm, "_ar_beats"}, ar_beats - ar0, ea);
      end

      chk("prot_strb_violations", prot_strb_bad, 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire

// File: doc/npu_axil_master.md
# npu_axil_master

AXI4-Lite initiator that drives the NPU's register slave from an on-chip command stream, so a sequencer (or boot ROM walker) can load layer/neuron selects, weights and biases, poll the status register and collect the classification result without a processor. It accepts one command at a time (write, read, or poll-until-mask), runs the matching AXI4-Lite transaction(s), and returns a single response beat per command.

## Interface
- C_M_AXI_ADDR_WIDTH, 5, AXI address width.
- C_M_AXI_DATA_WIDTH, 32, AXI data width (only 32 supported).
- POLL_LIMIT, 1024, maximum read attempts per poll command (≥1).
- M_AXI_ACLK  in  1  single clock.
- M_AXI_ARESET  in  1  reset, synchronous, active-high.
- cmd_valid / cmd_ready  in/out  1  command handshake.
- cmd_op  in  2  0=WRITE, 1=READ, 2=POLL, 3=reserved.
- cmd_addr  in  ADDR_WIDTH  byte address.
- cmd_data  in  DATA_WIDTH  write data (WRITE) or bit mask (POLL); ignored for READ.
- rsp_valid / rsp_ready  out/in  1  response handshake.
- rsp_data  out  DATA_WIDTH  read data (READ/POLL: last RDATA), 0 for WRITE.
- rsp_resp  out  2  AXI BRESP/RRESP of the last beat; 2'b10 (SLVERR) for reserved op.
- rsp_timeout  out  1  POLL exhausted POLL_LIMIT attempts.
- busy  out  1  high in every state except IDLE.
- M_AXI_AW{ADDR,PROT,VALID,READY}, M_AXI_W{DATA,STRB,VALID,READY}, M_AXI_B{RESP,VALID,READY}, M_AXI_AR{ADDR,PROT,VALID,READY}, M_AXI_R{DATA,RESP,VALID,READY}  standard AXI4-Lite master directions/widths.

## Operation
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP.
- IDLE: cmd_ready=1. On cmd_valid&cmd_ready, latch op/addr/data; WRITE→WR_REQ, READ/POLL→RD_REQ (poll counter cleared to 0), reserved→RSP with rsp_resp=2'b10.
- WR_REQ: AWVALID and WVALID rise together; each drops independently after its own handshake; when both done → WR_RESP. AW and W never issued apart (slave requires both valid simultaneously).
- WR_RESP: BREADY=1; on BVALID capture BRESP → RSP.
- RD_REQ: ARVALID=1 until ARREADY → RD_DATA. RD_DATA: RREADY=1; on RVALID capture RDATA/RRESP.
  - READ → RSP.
  - POLL: if (RDATA & mask)≠0 or RRESP≠OKAY → RSP; else counter+1; counter==POLL_LIMIT → RSP with rsp_timeout=1; otherwise → RD_REQ (re-issue).
- RSP: rsp_valid=1, fields stable until rsp_ready; then IDLE.
- WSTRB=4'hF, AWPROT=ARPROT=3'b000 always. Addresses driven from latched cmd_addr.
- Polling the status register clears it in the slave; the returned rsp_data is the beat that satisfied the mask.

## Timing
- Reset: all VALID/READY outputs 0, cmd_ready 0 during reset, 1 first cycle after; rsp_* 0, busy 0, state IDLE. Reset mid-transaction abandons it immediately (valids low next edge); no completion response.
- All outputs registered; no combinational path from any input to any output.
- Command accept → AWVALID/WVALID/ARVALID high next cycle.
- Final B/R handshake → rsp_valid next cycle.
- Against the NPU slave (ready one cycle after valid, response one cycle after handshake): WRITE accept→rsp_valid = 4 cycles; READ = 4 cycles; each extra poll attempt adds 3 cycles.
- Back-to-back: next cmd accepted the cycle after rsp handshake.
- Held rsp_ready low: no new command accepted, AXI idle.

## Structure
- Package npu_axil_pkg: op codes, AXI resp codes, NPU register offsets (WEIGHT 0x00, BIAS 0x04, OUT 0x08, LAYER 0x0C, NEURON 0x10, RDDATA 0x14, STAT 0x18, CTRL 0x1C), state enum.
- Single module; no sub-module (poll counter $clog2(POLL_LIMIT+1) bits inline).

## Test plan
- WRITE addr 0x0C data 0x2 to slave model → one AW+W beat with WSTRB F, rsp_valid after 4 cycles, rsp_resp 0, rsp_data 0.
- READ addr 0x0C after that write → rsp_data 0x2, rsp_resp 0.
- POLL addr 0x18 mask 0x1, nnOut_valid pulsed after 20 cycles → several reads, rsp_data 0x1, rsp_timeout 0, status reg cleared.
- POLL_LIMIT=4, status never set → exactly 4 AR beats, rsp_timeout 1, rsp_data 0.
- Slave delays AWREADY 3 cycles after WREADY, BRESP=SLVERR; rsp_ready held low 5 cycles → WVALID drops first, AWVALID held, rsp_resp 2'b10 stable 5 cycles, cmd_ready low throughout.
- Reset asserted during WR_RESP and cmd_op=3 after → valids low next edge, no rsp; reserved op returns rsp_resp 2'b10 with no AXI traffic.
